// File: rtl/phase_seq_pkg.sv
// Shared constants for the phase sequencer: default geometry, legacy strobe bit positions,
// the reset strobe table that reproduces the legacy 8-phase timing, and the step-mode state type.
package phase_seq_pkg;

    localparam int SEQ_NUM_PHASES  = 8;
    localparam int SEQ_NUM_STROBES = 5;

    localparam int STB_PC    = 0;
    localparam int STB_OPRAM = 1;
    localparam int STB_MEM   = 2;
    localparam int STB_ACC   = 3;
    localparam int STB_ALU   = 4;

    localparam logic [SEQ_NUM_STROBES-1:0] P_PC    = SEQ_NUM_STROBES'(1 << STB_PC);
    localparam logic [SEQ_NUM_STROBES-1:0] P_OPRAM = SEQ_NUM_STROBES'(1 << STB_OPRAM);
    localparam logic [SEQ_NUM_STROBES-1:0] P_MEM   = SEQ_NUM_STROBES'(1 << STB_MEM);
    localparam logic [SEQ_NUM_STROBES-1:0] P_ACC   = SEQ_NUM_STROBES'(1 << STB_ACC);
    localparam logic [SEQ_NUM_STROBES-1:0] P_ALU   = SEQ_NUM_STROBES'(1 << STB_ALU);
    localparam logic [SEQ_NUM_STROBES-1:0] P_IDLE  = '0;

    // Concatenated p7 down to p0; evaluates to 40'h00_00C8_3041.
    localparam logic [SEQ_NUM_PHASES*SEQ_NUM_STROBES-1:0] SEQ_DEFAULT_TABLE = {
        P_IDLE, P_IDLE, P_IDLE,
        P_MEM | P_ACC,
        P_ALU,
        P_MEM | P_ACC,
        P_OPRAM,
        P_PC
    };

    typedef enum logic {
        SEQ_RUN    = 1'b0,
        SEQ_PARKED = 1'b1
    } seq_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_strobe_table.sv
// Per-phase strobe pattern register file: reset-loaded from DEFAULT_TABLE, synchronous write,
// combinational read. Writes to addresses beyond the last phase are dropped.
module phase_strobe_table
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES  = SEQ_NUM_PHASES,
    parameter int NUM_STROBES = SEQ_NUM_STROBES,
    parameter int PHASE_W     = $clog2(NUM_PHASES),
    parameter int IDX_W       = idx_width(NUM_PHASES),
    parameter logic [NUM_PHASES*NUM_STROBES-1:0] DEFAULT_TABLE = SEQ_DEFAULT_TABLE
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_we,
    input  logic [PHASE_W-1:0]     i_wr_addr,
    input  logic [NUM_STROBES-1:0] i_wr_data,
    input  logic [IDX_W-1:0]       i_rd_addr,
    output logic [NUM_STROBES-1:0] o_rd_data
);

    logic [NUM_STROBES-1:0] r_entry [NUM_PHASES];
    logic                   w_wr_ok;
    logic [IDX_W-1:0]       w_wr_idx;

    // The address port may be wider than the table needs; range-check before truncating.
    assign w_wr_ok  = i_we && ({1'b0, i_wr_addr} < (PHASE_W + 1)'(NUM_PHASES));
    assign w_wr_idx = i_wr_addr[IDX_W-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < NUM_PHASES; p++) begin
                r_entry[p] <= DEFAULT_TABLE[p*NUM_STROBES +: NUM_STROBES];
            end
        end else if (w_wr_ok) begin
            r_entry[w_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_entry[i_rd_addr];

endmodule

// File: rtl/phase_sequencer.sv
// Runtime-length phase counter issuing one-cycle strobe patterns from a writable table.
// Optional SINGLE_STEP_EN adds step_mode/step/parked for one-cycle-at-a-time operation.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES  = SEQ_NUM_PHASES,
    parameter int NUM_STROBES = SEQ_NUM_STROBES,
    parameter int PHASE_W     = $clog2(NUM_PHASES),
    parameter logic [NUM_PHASES*NUM_STROBES-1:0] DEFAULT_TABLE = SEQ_DEFAULT_TABLE
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   stall,
    input  logic [PHASE_W-1:0]     last_phase,
    input  logic                   cfg_we,
    input  logic [PHASE_W-1:0]     cfg_addr,
    input  logic [NUM_STROBES-1:0] cfg_data,
`ifdef SINGLE_STEP_EN
    input  logic                   step_mode,
    input  logic                   step,
    output logic                   parked,
`endif
    output logic [NUM_STROBES-1:0] strobe,
    output logic [PHASE_W-1:0]     phase_out,
    output logic                   cycle_start
);

    localparam int                 IDX_W     = idx_width(NUM_PHASES);
    localparam logic [PHASE_W-1:0] MAX_PHASE = PHASE_W'(NUM_PHASES - 1);

    logic [PHASE_W-1:0]     r_phase;
    logic [NUM_STROBES-1:0] r_strobe;
    logic [PHASE_W-1:0]     r_phase_out;
    logic                   r_cycle_start;

    logic [PHASE_W-1:0]     w_eff_last;
    logic                   w_wrap;
    logic                   w_parked;
    logic                   w_advance;
    logic [NUM_STROBES-1:0] w_tbl_rd;

    phase_strobe_table #(
        .NUM_PHASES    (NUM_PHASES),
        .NUM_STROBES   (NUM_STROBES),
        .PHASE_W       (PHASE_W),
        .IDX_W         (IDX_W),
        .DEFAULT_TABLE (DEFAULT_TABLE)
    ) u_table (
        .i_clk     (clk_in),
        .i_rst_n   (rst),
        .i_we      (cfg_we),
        .i_wr_addr (cfg_addr),
        .i_wr_data (cfg_data),
        .i_rd_addr (r_phase[IDX_W-1:0]),
        .o_rd_data (w_tbl_rd)
    );

    // A shrunk cycle length is honoured at once: a phase beyond the new end issues and wraps.
    assign w_eff_last = (last_phase > MAX_PHASE) ? MAX_PHASE : last_phase;
    assign w_wrap     = (r_phase >= w_eff_last);

`ifdef SINGLE_STEP_EN
    seq_state_t r_state;

    assign w_parked = (r_state == SEQ_PARKED);
    assign parked   = w_parked;
`else
    assign w_parked = 1'b0;
`endif

    assign w_advance = ena & ~stall & ~w_parked;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_phase       <= '0;
            r_strobe      <= '0;
            r_phase_out   <= '0;
            r_cycle_start <= 1'b0;
`ifdef SINGLE_STEP_EN
            r_state       <= SEQ_RUN;
`endif
        end else begin
            if (w_advance) begin
                r_strobe      <= w_tbl_rd;
                r_phase_out   <= r_phase;
                r_cycle_start <= (r_phase == '0);
                r_phase       <= w_wrap ? '0 : r_phase + 1'b1;
            end else begin
                r_strobe      <= '0;
                r_cycle_start <= 1'b0;
            end
`ifdef SINGLE_STEP_EN
            // Park after the final phase issues; a step pulse or leaving step mode releases.
            case (r_state)
                SEQ_RUN: begin
                    if (w_advance && w_wrap && step_mode) begin
                        r_state <= SEQ_PARKED;
                    end
                end
                SEQ_PARKED: begin
                    if (!step_mode || step) begin
                        r_state <= SEQ_RUN;
                    end
                end
                default: r_state <= SEQ_RUN;
            endcase
`endif
        end
    end

    assign strobe      = r_strobe;
    assign phase_out   = r_phase_out;
    assign cycle_start = r_cycle_start;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed stimulus queues hand-computed outputs,
// a monitor pops and compares one entry per clock. Covers SINGLE_STEP_EN when defined.
`timescale 1ns/1ps
module tb_phase_sequencer;

    localparam int NP = 8;
    localparam int NS = 5;
    localparam int PW = 4;

    logic          clk_in     = 1'b0;
    logic          rst        = 1'b0;
    logic          ena        = 1'b0;
    logic          stall      = 1'b0;
    logic [PW-1:0] last_phase = '0;
    logic          cfg_we     = 1'b0;
    logic [PW-1:0] cfg_addr   = '0;
    logic [NS-1:0] cfg_data   = '0;
    logic [NS-1:0] strobe;
    logic [PW-1:0] phase_out;
    logic          cycle_start;
`ifdef SINGLE_STEP_EN
    logic          step_mode  = 1'b0;
    logic          step       = 1'b0;
    logic          parked;
`endif

    typedef struct packed {
        logic [NS-1:0] stb;
        logic [PW-1:0] ph;
        logic          cs;
        logic          pk;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    phase_sequencer #(
        .NUM_PHASES  (NP),
        .NUM_STROBES (NS),
        .PHASE_W     (PW)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .ena         (ena),
        .stall       (stall),
        .last_phase  (last_phase),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
`ifdef SINGLE_STEP_EN
        .step_mode   (step_mode),
        .step        (step),
        .parked      (parked),
`endif
        .strobe      (strobe),
        .phase_out   (phase_out),
        .cycle_start (cycle_start)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor: outputs are valid every cycle, so one queued entry is checked per edge.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_total++;
                if (strobe === e.stb && phase_out === e.ph && cycle_start === e.cs) begin
                    n_pass++;
                end else begin
                    $display("FAIL out@%0t: strobe=%h phase_out=%0d cycle_start=%b, required strobe=%h phase_out=%0d cycle_start=%b",
                             $time, strobe, phase_out, cycle_start, e.stb, e.ph, e.cs);
                end
`ifdef SINGLE_STEP_EN
                n_total++;
                if (parked === e.pk) begin
                    n_pass++;
                end else begin
                    $display("FAIL parked@%0t: got %b, required %b", $time, parked, e.pk);
                end
`endif
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, got, want);
    endtask

    // Drive one cycle of inputs (from a negedge) and queue the outputs required after the next posedge.
    task automatic cyc(input logic e, input logic s, input logic [PW-1:0] lp,
                       input logic [NS-1:0] xs, input logic [PW-1:0] xp, input logic xc,
                       input logic we = 1'b0, input logic [PW-1:0] a = '0,
                       input logic [NS-1:0] d = '0, input logic xk = 1'b0);
        exp_t x;
        ena        = e;
        stall      = s;
        last_phase = lp;
        cfg_we     = we;
        cfg_addr   = a;
        cfg_data   = d;
        x.stb = xs;
        x.ph  = xp;
        x.cs  = xc;
        x.pk  = xk;
        exp_q.push_back(x);
        @(negedge clk_in);
    endtask

    logic [NS-1:0] leg [NP];

    initial begin
        leg = '{5'h01, 5'h02, 5'h0C, 5'h10, 5'h0C, 5'h00, 5'h00, 5'h00};

        // Reset state
        #12;
        chk("reset_strobe", 8'(strobe), 8'h00);
        chk("reset_phase_out", 8'(phase_out), 8'h00);
        chk("reset_cycle_start", 8'(cycle_start), 8'h00);
        @(negedge clk_in);
        rst = 1'b1;

        // Legacy 8-phase cycle, two full turns
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 4'd7, leg[i % 8], PW'(i % 8), (i % 8) == 0);
        end

        // 4-phase cycle, then shrink to 2 phases while sitting at phase 3
        cyc(1'b1, 1'b0, 4'd3, 5'h01, 4'd0, 1'b1);
        cyc(1'b1, 1'b0, 4'd3, 5'h02, 4'd1, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, 5'h0C, 4'd2, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, 5'h10, 4'd3, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, 5'h01, 4'd0, 1'b1);
        cyc(1'b1, 1'b0, 4'd3, 5'h02, 4'd1, 1'b0);
        cyc(1'b1, 1'b0, 4'd3, 5'h0C, 4'd2, 1'b0);
        cyc(1'b1, 1'b0, 4'd1, 5'h10, 4'd3, 1'b0);
        cyc(1'b1, 1'b0, 4'd1, 5'h01, 4'd0, 1'b1);
        cyc(1'b1, 1'b0, 4'd1, 5'h02, 4'd1, 1'b0);

        // Stall with counter at phase 2, then ena low, then release
        cyc(1'b1, 1'b0, 4'd7, 5'h01, 4'd0, 1'b1);
        cyc(1'b1, 1'b0, 4'd7, 5'h02, 4'd1, 1'b0);
        cyc(1'b1, 1'b1, 4'd7, 5'h00, 4'd1, 1'b0);
        cyc(1'b1, 1'b1, 4'd7, 5'h00, 4'd1, 1'b0);
        cyc(1'b1, 1'b1, 4'd7, 5'h00, 4'd1, 1'b0);
        cyc(1'b0, 1'b0, 4'd7, 5'h00, 4'd1, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 5'h0C, 4'd2, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 5'h10, 4'd3, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 5'h0C, 4'd4, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 5'h00, 4'd5, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 5'h00, 4'd6, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 5'h00, 4'd7, 1'b0);
        cyc(1'b1, 1'b0, 4'd7, 5'h01, 4'd0, 1'b1);

        // Table writes: same-edge read sees old value, out-of-range addresses dropped,
        // write during stall, then last_phase=12 clamps to 7
        cyc(1'b1, 1'b0, 4'd1,  5'h02, 4'd1, 1'b0, 1'b1, 4'd1, 5'h1F);
        cyc(1'b1, 1'b0, 4'd1,  5'h01, 4'd0, 1'b1, 1'b1, 4'd9, 5'h00);
        cyc(1'b1, 1'b0, 4'd1,  5'h1F, 4'd1, 1'b0, 1'b1, 4'd8, 5'h1F);
        cyc(1'b1, 1'b0, 4'd1,  5'h01, 4'd0, 1'b1);
        cyc(1'b1, 1'b1, 4'd1,  5'h00, 4'd0, 1'b0, 1'b1, 4'd0, 5'h15);
        cyc(1'b0, 1'b0, 4'd12, 5'h00, 4'd0, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h1F, 4'd1, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h0C, 4'd2, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h10, 4'd3, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h0C, 4'd4, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h00, 4'd5, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h00, 4'd6, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h00, 4'd7, 1'b0);
        cyc(1'b1, 1'b0, 4'd12, 5'h15, 4'd0, 1'b1);
        cyc(1'b1, 1'b0, 4'd12, 5'h1F, 4'd1, 1'b0);

        // Asynchronous reset mid-cycle; restart must use the default table again
        ena = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_strobe", 8'(strobe), 8'h00);
        chk("async_rst_phase_out", 8'(phase_out), 8'h00);
        chk("async_rst_cycle_start", 8'(cycle_start), 8'h00);
        @(negedge clk_in);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 4'd7, 5'h01, 4'd0, 1'b1);
        cyc(1'b1, 1'b0, 4'd7, 5'h02, 4'd1, 1'b0);

`ifdef SINGLE_STEP_EN
        // Single-step: park after phase 4, step releases one more cycle, step_mode=0 releases
        step_mode = 1'b1;
        cyc(1'b1, 1'b0, 4'd4, 5'h0C, 4'd2, 1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
        cyc(1'b1, 1'b0, 4'd4, 5'h10, 4'd3, 1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
        cyc(1'b1, 1'b0, 4'd4, 5'h0C, 4'd4, 1'b0, 1'b0, 4'd0, 5'h00, 1'b1);
        cyc(1'b1, 1'b0, 4'd4, 5'h00, 4'd4, 1'b0, 1'b0, 4'd0, 5'h00, 1'b1);
        cyc(1'b1, 1'b0, 4'd4, 5'h00, 4'd4, 1'b0, 1'b0, 4'd0, 5'h00, 1'b1);
        step = 1'b1;
        cyc(1'b1, 1'b0, 4'd4, 5'h00, 4'd4, 1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
        step = 1'b0;
        cyc(1'b1, 1'b0, 4'd4, 5'h01, 4'd0, 1'b1, 1'b0, 4'd0, 5'h00, 1'b0);
        step = 1'b1;
        cyc(1'b1, 1'b0, 4'd4, 5'h02, 4'd1, 1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
        step = 1'b0;
        cyc(1'b1, 1'b0, 4'd4, 5'h0C, 4'd2, 1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
        cyc(1'b1, 1'b0, 4'd4, 5'h10, 4'd3, 1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
        cyc(1'b1, 1'b0, 4'd4, 5'h0C, 4'd4, 1'b0, 1'b0, 4'd0, 5'h00, 1'b1);
        cyc(1'b1, 1'b0, 4'd4, 5'h00, 4'd4, 1'b0, 1'b0, 4'd0, 5'h00, 1'b1);
        step_mode = 1'b0;
        cyc(1'b1, 1'b0, 4'd4, 5'h00, 4'd4, 1'b0, 1'b0, 4'd0, 5'h00, 1'b0);
        cyc(1'b1, 1'b0, 4'd4, 5'h01, 4'd0, 1'b1, 1'b0, 4'd0, 5'h00, 1'b0);
`endif

        ena = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_in);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d queued outputs unchecked, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
